// File: rtl/sad_disparity_select_pkg.sv
// rtl/sad_disparity_select_pkg.sv - shared stereo constants and abs-diff helper
package sad_disparity_select_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN      = 5;
  localparam int NCAND    = 4;
  localparam int COL_W    = 11;
  localparam int SAD_W    = 13;
  localparam int DISP_W   = 2;
  localparam int UNIQ_THR = 16;

  // Operands are widened before the subtract so the difference never wraps.
  function automatic logic [COL_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic [COL_W-1:0] wa;
    logic [COL_W-1:0] wb;
    wa = COL_W'(a);
    wb = COL_W'(b);
    return (wa > wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/sad_column_accum.sv
// rtl/sad_column_accum.sv - per-candidate column SAD and sliding-window running SAD
module sad_column_accum
  import sad_disparity_select_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [PIX_W*WIN-1:0]   left,
  input  logic [PIX_W*WIN-1:0]   right,
  input  logic                   col_valid,
  input  logic                   col_restart,
  input  logic                   col_clear,
  output logic [SAD_W-1:0]       sad
);

  logic [COL_W-1:0]          col_sum;
  logic [COL_W-1:0]          col_q;
  logic [WIN-1:0][COL_W-1:0] hist;

  always_comb begin
    col_sum = '0;
    for (int r = 0; r < WIN; r++) begin
      col_sum = col_sum + abs_diff(left[r*PIX_W +: PIX_W], right[r*PIX_W +: PIX_W]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
    end else if (in_valid) begin
      col_q <= col_sum;
    end
  end

  // hist[WIN-1] is the column leaving the window on the next advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      sad  <= '0;
    end else if (col_clear) begin
      hist <= '0;
      sad  <= '0;
    end else if (col_valid) begin
      if (col_restart) begin
        hist <= {{((WIN-1)*COL_W){1'b0}}, col_q};
        sad  <= SAD_W'(col_q);
      end else begin
        hist <= {hist[WIN-2:0], col_q};
        sad  <= sad + SAD_W'(col_q) - SAD_W'(hist[WIN-1]);
      end
    end
  end

endmodule

// File: rtl/sad_disparity_select.sv
// rtl/sad_disparity_select.sv - 4-candidate 5x5 SAD minimum select; SAD_UNIQUE_CHECK_EN adds disp_ambiguous
module sad_disparity_select
  import sad_disparity_select_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  line_start,
  input  logic [PIX_W*WIN-1:0]  out_left,
  input  logic [PIX_W*WIN-1:0]  out_right_1,
  input  logic [PIX_W*WIN-1:0]  out_right_2,
  input  logic [PIX_W*WIN-1:0]  out_right_3,
  input  logic [PIX_W*WIN-1:0]  out_right_4,
  output logic                  disp_valid,
  output logic [DISP_W-1:0]     disparity,
  output logic [SAD_W-1:0]      min_sad,
  output logic                  disp_ambiguous
);

  localparam int CNT_W = $clog2(WIN + 1);

  logic                 v1;
  logic                 ls1;
  logic                 clr1;
  logic                 v2;
  logic [CNT_W-1:0]     col_cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [PIX_W*WIN-1:0] right [NCAND];
  logic [SAD_W-1:0]     sad [NCAND];
  logic [SAD_W-1:0]     best;
  logic [DISP_W-1:0]    best_idx;

  assign right[0] = out_right_1;
  assign right[1] = out_right_2;
  assign right[2] = out_right_3;
  assign right[3] = out_right_4;

  // An idle line_start is delayed one stage so columns already in flight drain first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      ls1  <= 1'b0;
      clr1 <= 1'b0;
    end else begin
      v1   <= in_valid;
      ls1  <= in_valid & line_start;
      clr1 <= ~in_valid & line_start;
    end
  end

  always_comb begin
    if (ls1) begin
      cnt_nxt = CNT_W'(1);
    end else if (col_cnt == CNT_W'(WIN)) begin
      cnt_nxt = col_cnt;
    end else begin
      cnt_nxt = col_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt <= '0;
      v2      <= 1'b0;
    end else begin
      v2 <= v1 && (cnt_nxt >= CNT_W'(WIN));
      if (clr1) begin
        col_cnt <= '0;
      end else if (v1) begin
        col_cnt <= cnt_nxt;
      end
    end
  end

  for (genvar k = 0; k < NCAND; k++) begin : g_cand
    sad_column_accum u_accum (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .left        (out_left),
      .right       (right[k]),
      .col_valid   (v1),
      .col_restart (ls1),
      .col_clear   (clr1),
      .sad         (sad[k])
    );
  end

`ifdef SAD_UNIQUE_CHECK_EN
  logic [SAD_W-1:0] second;
`endif

  // Strict less-than scanning upward keeps ties on the lowest index.
  always_comb begin
    best     = sad[0];
    best_idx = '0;
`ifdef SAD_UNIQUE_CHECK_EN
    second   = '1;
`endif
    for (int k = 1; k < NCAND; k++) begin
      if (sad[k] < best) begin
`ifdef SAD_UNIQUE_CHECK_EN
        second = best;
`endif
        best     = sad[k];
        best_idx = DISP_W'(k);
      end
`ifdef SAD_UNIQUE_CHECK_EN
      else if (sad[k] < second) begin
        second = sad[k];
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_valid <= 1'b0;
      disparity  <= '0;
      min_sad    <= '0;
    end else begin
      disp_valid <= v2;
      if (v2) begin
        disparity <= best_idx;
        min_sad   <= best;
      end
    end
  end

`ifdef SAD_UNIQUE_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_ambiguous <= 1'b0;
    end else if (v2) begin
      disp_ambiguous <= (second - best) < SAD_W'(UNIQ_THR);
    end
  end
`else
  assign disp_ambiguous = 1'b0;
`endif

endmodule
